// File: rtl/mmio_arbiter.sv
// Data-memory port arbiter between the program loader and the core, with a
// memory-mapped console FIFO, a termination register and branch counters.
module mmio_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        ld_done,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        prmiss,
  input  logic        prsuccess,
  input  logic        combranch,
  output logic        con_valid,
  output logic [31:0] con_data,
  output logic        con_is_char,
  input  logic        con_ready,
  output logic        halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        cyc_q, cyc_d, prnum_q, prnum_d;
  logic [31:0]        prsu_q, prsu_d, prmi_q, prmi_d, prcom_q, prcom_d;
  logic [31:0]        fifo_data_q [FIFO_DEPTH];
  logic               fifo_char_q [FIFO_DEPTH];

  logic               mmio_hit, con_store, halt_store;
  logic               fifo_full, fifo_empty, push, pop;
  logic [31:0]        push_data;
  logic               push_char;

  assign mmio_hit   = (core_addr[31:6] == 26'd0);
  assign con_store  = core_we && ((core_addr == 32'h0) || (core_addr == 32'h4));
  assign halt_store = core_we && (core_addr == 32'h8);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Push is judged on the occupancy at cycle start, so a same-cycle pop never frees a slot.
  assign push      = (state_q == S_RUN) && con_store && !fifo_full;
  assign pop       = !fifo_empty && con_ready;
  assign push_char = (core_addr[2] == 1'b0);
  assign push_data = push_char ? {24'd0, core_wdata[7:0]} : core_wdata;

  // State register
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) state_q <= S_LOAD;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (ld_done)        state_d = S_RUN;
      S_RUN:   if (halt_store)     state_d = S_DRAIN;
      S_DRAIN: if (count_d == '0)  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Output logic
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    core_stall = 1'b1;
    halted     = 1'b0;
    case (state_q)
      S_LOAD: begin
        // Gate with reset so the loader cannot write while reset is held.
        mem_we    = ld_req && reset_x;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      S_RUN: begin
        mem_we     = core_we && !mmio_hit;
        core_stall = con_store && fifo_full;
      end
      S_DRAIN: ;
      default: halted = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    cyc_d    = cyc_q;
    prnum_d  = prnum_q;
    prsu_d   = prsu_q;
    prmi_d   = prmi_q;
    prcom_d  = prcom_q;
    if (state_q == S_RUN) begin
      cyc_d   = cyc_q + 32'd1;
      prnum_d = prnum_q + {31'd0, prmiss} + {31'd0, prsuccess};
      prsu_d  = prsu_q + {31'd0, prsuccess};
      prmi_d  = prmi_q + {31'd0, prmiss};
      prcom_d = prcom_q + {31'd0, combranch};
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cyc_q    <= '0;
      prnum_q  <= '0;
      prsu_q   <= '0;
      prmi_q   <= '0;
      prcom_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cyc_q    <= cyc_d;
      prnum_q  <= prnum_d;
      prsu_q   <= prsu_d;
      prmi_q   <= prmi_d;
      prcom_q  <= prcom_d;
    end
  end

  // Payload storage carries no reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_char_q[wr_ptr_q] <= push_char;
    end
  end

  assign con_valid   = !fifo_empty;
  assign con_data    = fifo_data_q[rd_ptr_q];
  assign con_is_char = fifo_char_q[rd_ptr_q];

  always_comb begin
    core_rdata = mem_rdata;
    if (mmio_hit) begin
      case (core_addr[5:0])
        6'h10:   core_rdata = cyc_q;
        6'h14:   core_rdata = prnum_q;
        6'h18:   core_rdata = prsu_q;
        6'h1C:   core_rdata = prmi_q;
        6'h20:   core_rdata = prcom_q;
        default: core_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: loader handoff, console FIFO, counters,
// drain/halt sequencing and asynchronous reset.
module tb_mmio_arbiter;

  logic        clk;
  logic        reset_x;
  logic        ld_req, ld_done, core_we;
  logic [31:0] ld_addr, ld_wdata, core_addr, core_wdata, core_rdata;
  logic        core_stall, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        prmiss, prsuccess, combranch;
  logic        con_valid, con_is_char, con_ready, halted;
  logic [31:0] con_data;

  int n_checks = 0;
  int n_errors = 0;
  int run_cycles = 0;
  bit in_run = 0;

  mmio_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_x(reset_x),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .prmiss(prmiss), .prsuccess(prsuccess), .combranch(combranch),
    .con_valid(con_valid), .con_data(con_data), .con_is_char(con_is_char),
    .con_ready(con_ready), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the edge counts as a RUN cycle if the model says RUN.
  task automatic step();
    @(posedge clk);
    if (in_run) run_cycles++;
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    core_addr = addr;
    #1;
    check(tag, core_rdata, exp);
  endtask

  initial begin
    reset_x = 1'b0; ld_req = 1'b1; ld_addr = 32'h100; ld_wdata = 32'hDEADBEEF; ld_done = 1'b0;
    core_we = 1'b1; core_addr = 32'h200; core_wdata = 32'h5; mem_rdata = 32'hCAFEF00D;
    prmiss = 1'b0; prsuccess = 1'b0; combranch = 1'b0; con_ready = 1'b0;
    #2;
    check("rst_con_valid", con_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_stall", core_stall, 1);
    check("rst_mem_we", mem_we, 0);
    step(); step();
    reset_x = 1'b1;
    #1;

    // Loader owns the port
    check("ld_mem_we", mem_we, 1);
    check("ld_mem_addr", mem_addr, 32'h100);
    check("ld_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("ld_stall", core_stall, 1);
    step();
    ld_done = 1'b1;
    step();
    ld_done = 1'b0; in_run = 1'b1;
    #1;
    check("run_mem_addr", mem_addr, 32'h200);
    check("run_mem_we", mem_we, 1);
    check("run_mem_wdata", mem_wdata, 32'h5);
    check("run_stall", core_stall, 0);
    core_we = 1'b0;
    #1;
    check("run_ld_ignored", mem_we, 0);
    step();

    // MMIO window boundary
    core_we = 1'b1; core_addr = 32'h3C; core_wdata = 32'h77;
    #1;
    check("win_3c_mem_we", mem_we, 0);
    check("win_3c_stall", core_stall, 0);
    step();
    check("win_3c_no_push", con_valid, 0);
    core_addr = 32'h40;
    #1;
    check("win_40_mem_we", mem_we, 1);
    check("win_40_addr", mem_addr, 32'h40);
    step();

    // Fill the console FIFO with chars
    for (int i = 0; i < 4; i++) begin
      core_we = 1'b1; core_addr = 32'h0; core_wdata = 32'hABCD0041 + i;
      #1;
      check($sformatf("fill_stall_%0d", i), core_stall, 0);
      check($sformatf("fill_mem_we_%0d", i), mem_we, 0);
      step();
    end
    check("full_valid", con_valid, 1);
    check("full_head", con_data, 32'h41);
    core_wdata = 32'hABCD0045;
    #1;
    check("fifth_stall", core_stall, 1);
    step();
    con_ready = 1'b1;
    #1;
    check("pop_full_stall", core_stall, 1);
    check("head0", con_data, 32'h41);
    check("head0_char", con_is_char, 1);
    step();
    check("fifth_admitted", core_stall, 0);
    check("head1", con_data, 32'h42);
    step();
    core_we = 1'b0;
    for (int i = 2; i < 5; i++) begin
      #1;
      check($sformatf("head%0d", i), con_data, 32'h41 + i);
      check($sformatf("head%0d_char", i), con_is_char, 1);
      step();
    end
    check("fifo_drained", con_valid, 0);
    con_ready = 1'b0;

    // Branch counters
    prmiss = 1'b1; prsuccess = 1'b1; combranch = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) combranch = 1'b0;
      if (c == 3) begin prmiss = 1'b0; prsuccess = 1'b0; end
      step();
    end
    read_chk("cnt_cyc", 32'h10, run_cycles);
    read_chk("cnt_prnum", 32'h14, 32'd6);
    read_chk("cnt_prsu", 32'h18, 32'd3);
    read_chk("cnt_prmi", 32'h1C, 32'd3);
    read_chk("cnt_prcom", 32'h20, 32'd2);
    read_chk("rd_mmio_other", 32'h24, 32'd0);
    read_chk("rd_mem", 32'h300, 32'hCAFEF00D);
    step();

    // Decimal push, then terminate
    core_we = 1'b1; core_addr = 32'h4; core_wdata = 32'd1234;
    #1;
    check("dec_stall", core_stall, 0);
    step();
    core_addr = 32'h8; core_wdata = 32'h0;
    #1;
    check("term_mem_we", mem_we, 0);
    step();
    in_run = 1'b0; core_we = 1'b0;
    #1;
    check("drain_halted", halted, 0);
    check("drain_valid", con_valid, 1);
    check("drain_stall", core_stall, 1);
    core_we = 1'b1; core_addr = 32'h4; core_wdata = 32'd99; prmiss = 1'b1;
    #1;
    check("drain_drop_we", mem_we, 0);
    core_addr = 32'h500;
    #1;
    check("drain_drop_mem", mem_we, 0);
    step();
    core_we = 1'b0; prmiss = 1'b0;
    read_chk("frozen_cyc", 32'h10, run_cycles);
    read_chk("frozen_prmi", 32'h1C, 32'd3);
    con_ready = 1'b1;
    #1;
    check("drain_head", con_data, 32'd1234);
    check("drain_head_char", con_is_char, 0);
    step();
    check("halt_halted", halted, 1);
    check("halt_valid", con_valid, 0);
    step();
    check("halt_sticky", halted, 1);

    // Reset during DRAIN with two entries pending
    con_ready = 1'b0;
    reset_x = 1'b0;
    #1;
    reset_x = 1'b1; run_cycles = 0;
    step();
    ld_done = 1'b1;
    step();
    ld_done = 1'b0; in_run = 1'b1;
    core_we = 1'b1; core_addr = 32'h0; core_wdata = 32'h61; combranch = 1'b1;
    step();
    core_addr = 32'h4; core_wdata = 32'd7;
    step();
    core_addr = 32'h8; combranch = 1'b0;
    step();
    in_run = 1'b0; core_we = 1'b0;
    #1;
    check("pre_rst_valid", con_valid, 1);
    check("pre_rst_halted", halted, 0);
    read_chk("pre_rst_cyc", 32'h10, run_cycles);
    #2;
    reset_x = 1'b0;
    #1;
    check("arst_valid", con_valid, 0);
    check("arst_halted", halted, 0);
    check("arst_stall", core_stall, 1);
    check("arst_mem_we", mem_we, 0);
    read_chk("arst_cyc", 32'h10, 32'd0);
    read_chk("arst_prcom", 32'h20, 32'd0);
    step();
    reset_x = 1'b1;
    #1;
    check("post_rst_load_we", mem_we, 1);
    check("post_rst_load_addr", mem_addr, 32'h100);
    check("post_rst_stall", core_stall, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
